// File: rtl/dff_delay_bank.sv
// dff_delay_bank: multi-lane signed delay line with per-stage valid bits,
// shared clock enable, synchronous flush and a registered occupancy count.
// Used to re-time activations, weights and partial sums so that operands
// produced at different pipeline depths meet at the same stage.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   enable          1 = all stages advance, 0 = all stages hold
//   flush           synchronous clear of every stage, wins over enable
//   in_valid        qualifies in_data; an invalid word enters as all zeros
//   in_data         CHANNELS packed lanes, lane c = [c*DWIDTH +: DWIDTH]
//   delay_sel       output tap 1..DEPTH; 0 or >DEPTH selects stage DEPTH
//   out_valid       valid bit of the tapped stage (combinational)
//   out_data        data of the tapped stage (combinational), same packing
//   occupancy       number of stages currently holding valid data

// One lane: DEPTH data registers plus the combinational output tap.
// tap arrives already sanitised to 1..DEPTH by the top level.
module dff_delay_lane #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4,
  parameter int SELW   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              clear,
  input  logic [DWIDTH-1:0] in_word,
  input  logic [SELW-1:0]   tap,
  output logic [DWIDTH-1:0] out_word
);
  logic [DEPTH:1][DWIDTH-1:0] stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else if (clear) begin
      stage <= '0;
    end else if (advance) begin
      stage[1] <= in_word;
      for (int k = 2; k <= DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  always_comb begin
    out_word = '0;
    for (int k = 1; k <= DEPTH; k++)
      if (tap == SELW'(k)) out_word = stage[k];
  end
endmodule

module dff_delay_bank #(
  parameter int DWIDTH   = 32,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [CHANNELS*DWIDTH-1:0]   in_data,
  input  logic [$clog2(DEPTH+1)-1:0]   delay_sel,
  output logic                         out_valid,
  output logic [CHANNELS*DWIDTH-1:0]   out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int SELW = $clog2(DEPTH+1);

  logic [CHANNELS-1:0][DWIDTH-1:0] in_lanes, out_lanes;
  logic [DEPTH:1]                  vld_pipe;
  logic [SELW-1:0]                 tap;
  logic                            advance;

  // flush has priority, so it masks the advance strobe.
  assign advance = enable & ~flush;

  // Invalid words enter as zero so bubbles never carry stale data.
  assign in_lanes = in_valid ? in_data : '0;
  assign out_data = out_lanes;

  // Out-of-range selects fall back to the deepest stage.
  assign tap = (delay_sel == '0 || delay_sel > SELW'(DEPTH)) ? SELW'(DEPTH) : delay_sel;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    dff_delay_lane #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .SELW(SELW)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .advance  (advance),
      .clear    (flush),
      .in_word  (in_lanes[c]),
      .tap      (tap),
      .out_word (out_lanes[c])
    );
  end

  // Valid shift register and occupancy move on the same edge as the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      occupancy <= '0;
    end else if (flush) begin
      vld_pipe  <= '0;
      occupancy <= '0;
    end else if (enable) begin
      vld_pipe[1] <= in_valid;
      for (int k = 2; k <= DEPTH; k++) vld_pipe[k] <= vld_pipe[k-1];
      // Entry and exit together leave the count unchanged; the count
      // tracks set valid bits exactly, so it cannot wrap.
      if (in_valid && !vld_pipe[DEPTH])      occupancy <= occupancy + SELW'(1);
      else if (!in_valid && vld_pipe[DEPTH]) occupancy <= occupancy - SELW'(1);
    end
  end

  always_comb begin
    out_valid = 1'b0;
    for (int k = 1; k <= DEPTH; k++)
      if (tap == SELW'(k)) out_valid = vld_pipe[k];
  end
endmodule

// File: tb/tb_dff_delay_bank.sv
// Testbench for dff_delay_bank (DWIDTH=32, CHANNELS=4, DEPTH=4).
// Table vectors, directed corner sequences and random traffic checked
// against a history-queue reference model.
module tb_dff_delay_bank;
  localparam int DW = 32, CH = 4, DP = 4, SW = 3;
  localparam int BW = CH*DW;

  logic          clk = 1'b0;
  logic          rst_n, enable, flush, in_valid;
  logic [BW-1:0] in_data;
  logic [SW-1:0] delay_sel;
  logic          out_valid;
  logic [BW-1:0] out_data;
  logic [SW-1:0] occupancy;

  int n_chk = 0, n_fail = 0;

  dff_delay_bank #(.DWIDTH(DW), .CHANNELS(CH), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .delay_sel(delay_sel),
    .out_valid(out_valid), .out_data(out_data), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Reference: the last DP accepted entries, newest at index 0.
  typedef struct { bit v; logic [BW-1:0] d; } ent_t;
  ent_t hist[$];

  function automatic void model_clear();
    ent_t z;
    z.v = 1'b0; z.d = '0;
    hist.delete();
    for (int i = 0; i < DP; i++) hist.push_back(z);
  endfunction

  function automatic void model_edge(bit fl, bit en, bit iv, logic [BW-1:0] d);
    ent_t e;
    if (fl) model_clear();
    else if (en) begin
      e.v = iv; e.d = iv ? d : '0;
      hist.push_front(e);
      void'(hist.pop_back());
    end
  endfunction

  function automatic int norm(logic [SW-1:0] s);
    return (s == 0 || s > DP) ? DP : int'(s);
  endfunction

  function automatic int model_occ();
    int n = 0;
    foreach (hist[i]) if (hist[i].v) n++;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    ent_t e;
    e = hist[norm(delay_sel)-1];
    chk({tag, "_valid"}, BW'(out_valid), BW'(e.v));
    chk({tag, "_data"}, out_data, e.d);
    chk({tag, "_occ"}, BW'(occupancy), BW'(model_occ()));
  endtask

  task automatic step(input bit fl, input bit en, input bit iv,
                      input logic [BW-1:0] d, input logic [SW-1:0] sel);
    flush = fl; enable = en; in_valid = iv; in_data = d; delay_sel = sel;
    @(posedge clk);
    model_edge(fl, en, iv, d);
    #1;
  endtask

  typedef struct {
    bit fl, en, iv; logic [31:0] d0; logic [SW-1:0] sel;
    bit ev; logic [31:0] ed0; int eo;
  } vec_t;
  vec_t tbl[$];

  initial begin
    int sels[6];
    logic [BW-1:0] sdata;
    logic [31:0] stall_exp[3];

    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; delay_sel = 3'd4;
    model_clear();

    // Occupancy pattern 1,0,1,1,0,0,0,0 tapped at stage 4.
    tbl.push_back('{0,1,1,32'hA1,3'd4, 0,32'h0 ,1});
    tbl.push_back('{0,1,0,32'hA2,3'd4, 0,32'h0 ,1});
    tbl.push_back('{0,1,1,32'hA3,3'd4, 0,32'h0 ,2});
    tbl.push_back('{0,1,1,32'hA4,3'd4, 1,32'hA1,3});
    tbl.push_back('{0,1,0,32'hA5,3'd4, 0,32'h0 ,2});
    tbl.push_back('{0,1,0,32'hA6,3'd4, 1,32'hA3,2});
    tbl.push_back('{0,1,0,32'hA7,3'd4, 1,32'hA4,1});
    tbl.push_back('{0,1,0,32'hA8,3'd4, 0,32'h0 ,0});
    // Fill to 4, then in and out together; sel 0 and 7 act as 4.
    tbl.push_back('{0,1,1,32'h10,3'd4, 0,32'h0 ,1});
    tbl.push_back('{0,1,1,32'h11,3'd4, 0,32'h0 ,2});
    tbl.push_back('{0,1,1,32'h12,3'd4, 0,32'h0 ,3});
    tbl.push_back('{0,1,1,32'h13,3'd4, 1,32'h10,4});
    tbl.push_back('{0,1,1,32'h14,3'd0, 1,32'h11,4});
    tbl.push_back('{0,1,1,32'h15,3'd7, 1,32'h12,4});
    // Flush beats enable/in_valid; 0x55 must never appear.
    tbl.push_back('{1,1,1,32'h55,3'd4, 0,32'h0 ,0});
    tbl.push_back('{0,1,0,32'hAA,3'd1, 0,32'h0 ,0});
    tbl.push_back('{0,1,0,32'hAA,3'd2, 0,32'h0 ,0});
    tbl.push_back('{0,1,0,32'hAA,3'd3, 0,32'h0 ,0});
    tbl.push_back('{0,1,0,32'hAA,3'd4, 0,32'h0 ,0});

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", BW'(out_valid), '0);
    chk("reset_data", out_data, '0);
    chk("reset_occ", BW'(occupancy), '0);
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].fl, tbl[i].en, tbl[i].iv, BW'(tbl[i].d0), tbl[i].sel);
      chk($sformatf("tbl%0d_valid", i), BW'(out_valid), BW'(tbl[i].ev));
      chk($sformatf("tbl%0d_lane0", i), BW'(out_data[31:0]), BW'(tbl[i].ed0));
      chk($sformatf("tbl%0d_occ", i), BW'(occupancy), BW'(tbl[i].eo));
    end

    // Latency sweep: lane0 = k on the k-th edge lags by the tap depth.
    sels = '{1, 2, 3, 4, 0, 7};
    foreach (sels[i]) begin
      step(1, 0, 0, '0, SW'(sels[i]));
      for (int k = 1; k <= 7; k++) begin
        int n, e;
        step(0, 1, 1, BW'(k), SW'(sels[i]));
        n = norm(SW'(sels[i]));
        e = (k >= n) ? k - n + 1 : 0;
        chk($sformatf("lat_sel%0d_k%0d", sels[i], k), BW'(out_data[31:0]), BW'(e));
        chk($sformatf("lat_sel%0d_k%0d_v", sels[i], k), BW'(out_valid), BW'(k >= n));
      end
    end

    // Stall: 0x10..0x12 in, three hold cycles presenting 0xFF, then drain.
    step(1, 0, 0, '0, 3'd3);
    step(0, 1, 1, BW'(32'h10), 3'd3);
    step(0, 1, 1, BW'(32'h11), 3'd3);
    step(0, 1, 1, BW'(32'h12), 3'd3);
    chk("stall_pre", BW'(out_data[31:0]), BW'(32'h10));
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, BW'(32'hFF), 3'd3);
      chk($sformatf("stall_hold%0d", i), BW'(out_data[31:0]), BW'(32'h10));
      chk($sformatf("stall_hold%0d_occ", i), BW'(occupancy), BW'(3));
    end
    stall_exp = '{32'h11, 32'h12, 32'h0};
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, '0, 3'd3);
      chk($sformatf("stall_rel%0d", i), BW'(out_data[31:0]), BW'(stall_exp[i]));
      check_model($sformatf("stall_rel%0d_m", i));
    end

    // Signed lanes pass bit-exact; a gap comes out as zero, invalid.
    sdata = {32'h0, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF};
    step(1, 0, 0, '0, 3'd1);
    step(0, 1, 1, sdata, 3'd1);
    chk("signed_lanes", out_data, sdata);
    step(0, 1, 0, {4{32'hDEADBEEF}}, 3'd1);
    chk("gap_data", out_data, '0);
    chk("gap_valid", BW'(out_valid), '0);
    delay_sel = 3'd2;
    #1;
    chk("retap_data", out_data, sdata);
    chk("retap_valid", BW'(out_valid), BW'(1));

    // Asynchronous reset mid-cycle with valid data in flight.
    step(0, 1, 1, BW'(32'h77), 3'd1);
    chk("prerst_valid", BW'(out_valid), BW'(1));
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    chk("async_rst_valid", BW'(out_valid), '0);
    chk("async_rst_data", out_data, '0);
    chk("async_rst_occ", BW'(occupancy), '0);
    @(negedge clk) rst_n = 1'b1;
    step(0, 1, 0, BW'(32'h99), 3'd1);
    check_model("post_rst");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1,
           {$urandom, $urandom, $urandom, $urandom},
           SW'($urandom_range(0, 7)));
      check_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dff_delay_bank.md
# dff_delay_bank

Parametrised multi-channel register bank that delays signed data words by a selectable number of clock cycles, with a valid flag per stage, global stall, synchronous flush and an occupancy counter. It is the standard pipeline-alignment element in the datapath: it re-times neuron activations, weights and partial sums so that operands produced at different pipeline depths meet at the same MAC or activation stage. All channels share one clock enable, so a stalled stage freezes every lane together.

## Interface
- DWIDTH, 32, bit width of one signed channel word
- CHANNELS, 4, number of parallel lanes sharing the pipeline
- DEPTH, 4, number of register stages (≥1); maximum delay in cycles
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- enable  input  1  1 = pipeline advances this cycle; 0 = every stage holds
- flush  input  1  synchronous clear of all stages; priority over enable
- in_valid  input  1  qualifies in_data
- in_data  input  CHANNELS*DWIDTH  packed signed lanes; lane c = bits [c*DWIDTH +: DWIDTH]
- delay_sel  input  $clog2(DEPTH+1)  output tap, 1..DEPTH cycles
- out_valid  output  1  valid bit of the selected stage
- out_data  output  CHANNELS*DWIDTH  data of the selected stage, same packing
- occupancy  output  $clog2(DEPTH+1)  number of stages holding valid data

## Operation
- Storage: stages S1..SDEPTH, each with CHANNELS×DWIDTH data plus one valid bit.
- Reset (rst_n=0, asynchronous, any time): all stage data = 0, all valid = 0, occupancy = 0. Hence out_valid = 0, out_data = 0 while reset is held and after release.
- Flush (flush=1 at a rising edge, rst_n=1): all stage data and valid bits clear to 0 and occupancy clears to 0, whatever the values of enable and in_valid. The input word presented that cycle is discarded.
- Advance (flush=0, enable=1):
  - S1 loads in_data and in_valid. When in_valid=0, S1 data loads 0, not in_data.
  - Sk loads Sk-1 for k = 2..DEPTH.
  - The word in SDEPTH leaves the bank.
- Hold (flush=0, enable=0): no register changes. in_data and in_valid are ignored, so a word presented during a stall is lost. The upstream block must hold off while enable=0.
- Output tap:
  - out_data and out_valid are a combinational mux of stage S[delay_sel]; there is no extra register.
  - delay_sel = 0 or delay_sel > DEPTH selects SDEPTH.
  - Changing delay_sel re-taps immediately. It does not move data.
- Lanes are passed bit-exact. No arithmetic, sign extension or saturation is applied.
- Occupancy is a registered counter, always equal to the number of set valid bits:
  - On advance: occupancy_next = occupancy + in_valid − valid(SDEPTH).
  - If in_valid=1 and valid(SDEPTH)=1 together, occupancy is unchanged.
  - The counter never wraps. Its range is 0..DEPTH.
- DEPTH=1 is legal. The bank is then a single enabled register with valid and flush.

## Timing
- Latency in_data → out_data equals delay_sel advancing cycles (enable=1 edges). Hold cycles add to the wall-clock latency without changing stage position.
- With continuous enable=1 and delay_sel=N, a word accepted at edge t appears on out_data right after edge t+N−1. It is visible during the cycle following edge t+N−1 and is replaced at edge t+N.
- Throughput: one word per enabled cycle, with no bubbles inserted.
- flush at edge t: out_valid=0 and occupancy=0 from after edge t. A word presented at edge t+1 is accepted normally.
- Reset deasserted mid-stream: the first edge with rst_n=1 behaves as a normal advance, flush or hold edge.
- occupancy updates on the same edge as the stage registers, with no lag.

## Test plan
- Reset: rst_n=0 asserted mid-cycle while valid data is in flight → out_valid=0, out_data=0 and occupancy=0 immediately, without waiting for a clock edge. They stay 0 after release until new data is accepted.
- Latency sweep: DEPTH=4, enable=1, in_valid=1, lane0 = 1,2,3,… each cycle, for delay_sel=1..4 → lane0 of out_data lags by exactly delay_sel edges. delay_sel=0 and delay_sel=7 behave as 4.
- Stall: stream 0x10,0x11,0x12; hold enable=0 for 3 cycles with in_data=0xFF → outputs frozen, 0xFF never appears. Release → 0x10,0x11,0x12 resume in order.
- Flush priority: fill all 4 stages (occupancy=4), then flush=1 with enable=1 and in_valid=1, in_data=0x55 → occupancy=0, out_valid=0, 0x55 never emerges.
- Occupancy: pattern in_valid=1,0,1,1,0,0,0,0 at DEPTH=4 → occupancy 1,1,2,3,2,2,1,0. Counter never exceeds 4 or underflows.
- Signed multi-lane: lanes = −1 (0xFFFFFFFF), 0x7FFFFFFF, 0x80000000, 0 → all four emerge bit-exact in their own lanes. A gap with in_valid=0 emerges as all-zero data with out_valid=0.
